// File: rtl/mcycle_datapath_pkg.sv
// Shared constants and helpers for the multi-cycle multiply/divide datapath
// and the control FSM that sequences it.
package mcycle_datapath_pkg;

    localparam logic MCYCLE_MUL = 1'b0;
    localparam logic MCYCLE_DIV = 1'b1;

    // Iteration counter must be able to hold the value width itself.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mcycle_sign_fix.sv
// Combinational sign correction of the unsigned shift-add / restoring-divide
// results: product, quotient and remainder.
module mcycle_sign_fix
    import mcycle_datapath_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             op,
    input  logic             neg_a,
    input  logic             neg_b,
    input  logic [width-1:0] r_lo,
    input  logic [width-1:0] q,
    output logic [width-1:0] result1,
    output logic [width-1:0] result2
);

    logic [2*width-1:0] prod;
    logic [width-1:0]   quo;
    logic [width-1:0]   rem;

    always_comb begin
        prod = {r_lo, q};
        if (neg_a ^ neg_b)
            prod = -prod;
        quo = (neg_a ^ neg_b) ? -q : q;
        // Remainder takes the sign of the dividend only.
        rem = neg_a ? -r_lo : r_lo;
        if (op == MCYCLE_DIV) begin
            result1 = quo;
            result2 = rem;
        end else begin
            result1 = prod[width-1:0];
            result2 = prod[2*width-1:width];
        end
    end

endmodule

// File: rtl/mcycle_datapath.sv
// Iterative shift-add multiply / restoring divide datapath, stepped one
// iteration per Shift by the external multi-cycle controller.
module mcycle_datapath
    import mcycle_datapath_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Init,
    input  logic             Shift,
    input  logic             Write,
    input  logic             MCycleOp,
    input  logic             Signed,
    input  logic [width-1:0] Operand1,
    input  logic [width-1:0] Operand2,
    output logic             Control,
    output logic [width-1:0] Result1,
    output logic [width-1:0] Result2
);

    localparam int CW = cnt_width(width);

    logic             op;
    logic             sgn;
    logic             neg_a;
    logic             neg_b;
    logic [width-1:0] a_reg;
    logic [width-1:0] q_reg;
    logic [width:0]   r_reg;
    logic [CW-1:0]    iter;

    logic [width-1:0] abs1;
    logic [width-1:0] abs2;
    logic [width:0]   sum;
    logic [width:0]   r_shl;
    logic [width:0]   t;
    logic             active;

    always_comb begin
        abs1   = (Signed && Operand1[width-1]) ? -Operand1 : Operand1;
        abs2   = (Signed && Operand2[width-1]) ? -Operand2 : Operand2;
        active = (iter < CW'(width));
        sum    = r_reg + (Write ? {1'b0, a_reg} : '0);
        r_shl  = {r_reg[width-1:0], q_reg[width-1]};
        t      = r_shl - {1'b0, a_reg};
        Control = (op == MCYCLE_DIV) ? ~t[width] : q_reg[0];
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            op    <= 1'b0;
            sgn   <= 1'b0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            a_reg <= '0;
            q_reg <= '0;
            r_reg <= '0;
            iter  <= '0;
        end else if (Init) begin
            op    <= MCycleOp;
            sgn   <= Signed;
            neg_a <= Signed & Operand1[width-1];
            neg_b <= Signed & Operand2[width-1];
            // Divide keeps the dividend in Q so it shifts into R bit by bit.
            if (MCycleOp == MCYCLE_DIV) begin
                a_reg <= abs2;
                q_reg <= abs1;
            end else begin
                a_reg <= abs1;
                q_reg <= abs2;
            end
            r_reg <= '0;
            iter  <= '0;
        end else if (Shift && active) begin
            iter <= iter + CW'(1);
            if (op == MCYCLE_MUL) begin
                {r_reg, q_reg} <= {sum, q_reg} >> 1;
            end else if (Write) begin
                r_reg <= t;
                q_reg <= {q_reg[width-2:0], 1'b1};
            end else begin
                r_reg <= r_shl;
                q_reg <= {q_reg[width-2:0], 1'b0};
            end
        end
    end

    mcycle_sign_fix #(.width(width)) u_sign_fix (
        .op      (op),
        .neg_a   (neg_a),
        .neg_b   (neg_b),
        .r_lo    (r_reg[width-1:0]),
        .q       (q_reg),
        .result1 (Result1),
        .result2 (Result2)
    );

endmodule

// File: tb/tb_mcycle_datapath.sv
// Self-checking bench for mcycle_datapath: directed corner cases plus
// randomized multiply/divide against an arithmetic reference model.
module tb_mcycle_datapath;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         Init;
    logic         Shift;
    logic         Write;
    logic         MCycleOp;
    logic         Signed;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic         Control;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    // The controller loops the step decision straight back as Write.
    assign Write = Control;

    mcycle_datapath #(.width(W)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Init     (Init),
        .Shift    (Shift),
        .Write    (Write),
        .MCycleOp (MCycleOp),
        .Signed   (Signed),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Control  (Control),
        .Result1  (Result1),
        .Result2  (Result2)
    );

    task automatic check_eq(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: magnitudes, plain * / %, then sign rules. Returns {Result2, Result1}.
    function automatic logic [2*W-1:0] model(input logic op, input logic sgn,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic         na;
        logic         nb;
        logic [W-1:0] ua;
        logic [W-1:0] ub;
        logic [2*W-1:0] p;
        logic [W-1:0] q;
        logic [W-1:0] r;
        na = sgn & a[W-1];
        nb = sgn & b[W-1];
        ua = na ? -a : a;
        ub = nb ? -b : b;
        if (!op) begin
            p = {{W{1'b0}}, ua} * {{W{1'b0}}, ub};
            if (na ^ nb) p = -p;
            return p;
        end
        if (ub == '0) begin
            q = '1;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (na ^ nb) q = -q;
        if (na) r = -r;
        return {r, q};
    endfunction

    task automatic start(input logic op, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        Init     = 1'b1;
        MCycleOp = op;
        Signed   = sgn;
        Operand1 = a;
        Operand2 = b;
        @(negedge CLK);
        Init = 1'b0;
    endtask

    task automatic shifts(input int n);
        Shift = 1'b1;
        repeat (n) @(negedge CLK);
        Shift = 1'b0;
    endtask

    task automatic run(input logic op, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        start(op, sgn, a, b);
        shifts(op ? W + 1 : W);
    endtask

    task automatic directed(input string tag, input logic op, input logic sgn,
                            input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
        run(op, sgn, a, b);
        check_eq(tag, {Result2, Result1}, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [2*W-1:0] hold;
        logic           op;
        logic           sg;
        logic [W-1:0]   a;
        logic [W-1:0]   b;

        Reset = 1'b1; Init = 1'b0; Shift = 1'b0;
        MCycleOp = 1'b0; Signed = 1'b0; Operand1 = '0; Operand2 = '0;
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        check_eq("reset_res", {Result2, Result1}, '0);
        check_eq("reset_ctl", {{(2*W-1){1'b0}}, Control}, '0);

        directed("umul_max",   1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        directed("smul_m7x6",  1'b0, 1'b1, 32'hFFFFFFF9, 32'd6,        64'hFFFFFFFF_FFFFFFD6);
        directed("smul_minsq", 1'b0, 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        directed("sdiv_m7d2",  1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD);
        directed("sdiv_7dm2",  1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
        directed("udiv_zero",  1'b1, 1'b0, 32'd100,      32'd0,        64'h00000064_FFFFFFFF);
        directed("sdiv_ovf",   1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);

        // Extra Shift pulses after completion must not disturb the results.
        hold = {Result2, Result1};
        repeat (5) begin
            Shift = 1'b1; @(negedge CLK);
            Shift = 1'b0; @(negedge CLK);
        end
        check_eq("extra_shift", {Result2, Result1}, hold);

        // Reset mid-operation, with Shift still asserted.
        start(1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF1);
        Shift = 1'b1;
        repeat (10) @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0; Shift = 1'b0;
        check_eq("midrst_res", {Result2, Result1}, '0);
        check_eq("midrst_ctl", {{(2*W-1){1'b0}}, Control}, '0);

        // Init at step 10 alongside Shift: restart wins and iter begins at 0.
        start(1'b0, 1'b0, 32'hDEADBEEF, 32'hCAFEF00D);
        Shift = 1'b1;
        repeat (10) @(negedge CLK);
        Init = 1'b1; MCycleOp = 1'b0; Signed = 1'b0; Operand1 = 32'd3; Operand2 = 32'd5;
        @(negedge CLK);
        Init = 1'b0;
        repeat (W) @(negedge CLK);
        Shift = 1'b0;
        check_eq("reinit_3x5", {Result2, Result1}, 64'd15);

        for (int i = 0; i < 48; i++) begin
            op = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : $urandom;
            b  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 9))  : $urandom;
            if ($urandom_range(0, 7) == 0) b = sg ? 32'hFFFFFFFF : 32'h0;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            run(op, sg, a, b);
            check_eq(op ? "rand_div" : "rand_mul", {Result2, Result1}, model(op, sg, a, b));
        end

        // Results must hold through idle cycles.
        hold = {Result2, Result1};
        repeat (4) @(negedge CLK);
        check_eq("idle_hold", {Result2, Result1}, hold);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mcycle_datapath.md
Name: mcycle_datapath

Overview:
- Iterative shift-add multiply and restoring-divide datapath.
- Driven cycle by cycle by the existing multi-cycle control FSM: it consumes Init/Shift/Write and returns Control.
- Sits between the ALU-side operand muxes and the writeback selection for multiply/divide instructions.
- Produces a double-width product, or a quotient and remainder, with optional signed operation.

Parameters:
- width, 32, operand width in bits (even, ≥4).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset; clears all state.
- Init  in  1  load operands and clear the iteration state.
- Shift  in  1  perform one iteration step this cycle.
- Write  in  1  commit this step's add/subtract (the controller loops Control back as Write).
- MCycleOp  in  1  0 = multiply, 1 = divide; sampled on Init.
- Signed  in  1  1 = two's-complement operands; sampled on Init.
- Operand1  in  width  multiplicand / dividend.
- Operand2  in  width  multiplier / divisor.
- Control  out  1  step decision for the controller (combinational from registers).
- Result1  out  width  product low half / quotient.
- Result2  out  width  product high half / remainder.

Behaviour:
- Registers: op, sgn, negA, negB, A (width), Q (width), R (width+1), iter (log2(width)+1 bits).
- Reset: all registers 0, so Control = 0, Result1 = 0, Result2 = 0.
- Priority: Reset > Init > Shift.
- On Init:
  - Latch op = MCycleOp and sgn = Signed.
  - negA = Signed & Operand1[msb]; negB = Signed & Operand2[msb].
  - A = |Operand1| and Q = |Operand2| when Signed, else raw.
  - Multiply: A = multiplicand, Q = multiplier. Divide: the dividend goes to Q and the divisor to A.
  - R = 0, iter = 0.
- Multiply step (Shift & iter < width):
  - sum = R + (Write ? A : 0), width+1 bits.
  - {R, Q} <= {sum, Q} >> 1 (logical right shift).
  - iter++.
  - Control = Q[0].
- Divide step (Shift & iter < width):
  - t = {R[width-1:0], Q[msb]} - {1'b0, A}, width+1 bits.
  - Control = ~t[width] (no borrow), computed from current registers.
  - If Write: R <= t and Q <= {Q[width-2:0], 1'b1}.
  - Else: R <= {R[width-1:0], Q[msb]} and Q <= {Q[width-2:0], 1'b0}.
  - iter++.
- Shift when iter == width: ignored; all registers hold. This absorbs the controller's extra divide cycle and any trailing Shift.
- Latency: results are valid the cycle after the width-th accepted Shift (multiply: width Shift cycles; divide: controller supplies width+1, the last is a no-op).
- Results are combinational from the registers:
  - Multiply: P = {R[width-1:0], Q}. If negA^negB, P = -P (2·width-bit two's complement). Result2 = P[2w-1:w], Result1 = P[w-1:0].
  - Divide: quotient = Q, negated if negA^negB; remainder = R[width-1:0], negated if negA. Result1 = quotient, Result2 = remainder.
- Divide by zero: natural restoring outcome.
  - Unsigned: quotient all ones, remainder = dividend.
  - Signed: sign fix-up applies as above; no trap.
- Signed overflow (most-negative ÷ −1): quotient = most-negative value (wraps), remainder = 0.
- Init during an operation: the current operation is discarded and the new operands load. Reset mid-operation: full clear.
- Results hold indefinitely after completion until the next Init or Reset.

Decomposition:
- Shared package:
  - MCYCLE_MUL = 1'b0 and MCYCLE_DIV = 1'b1 constants, shared with the controller.
  - A clog2-based counter-width function.
- One natural sub-module: mcycle_sign_fix. It is combinational: conditional two's-complement negation of the product, quotient and remainder from negA/negB/op.
- All state stays in mcycle_datapath.

Test Plan:
- Unsigned multiply, width=32: Init with 0xFFFFFFFF × 0xFFFFFFFF, then 32 Shifts with Write = Control → Result2 = 0xFFFFFFFE, Result1 = 0x00000001.
- Signed multiply: −7 × 6 → {Result2, Result1} = 0xFFFFFFFF_FFFFFFD6 (−42). 0x80000000 × 0x80000000 → Result2 = 0x40000000, Result1 = 0.
- Signed divide, 33 Shifts: −7 ÷ 2 → Result1 = 0xFFFFFFFD (−3), Result2 = 0xFFFFFFFF (−1). 7 ÷ −2 → quotient −3, remainder 1.
- Divide by zero, unsigned: 100 ÷ 0 → Result1 = 0xFFFFFFFF, Result2 = 100. Signed overflow: 0x80000000 ÷ 0xFFFFFFFF → Result1 = 0x80000000, Result2 = 0.
- Interruptions:
  - Reset asserted after 10 Shifts → Result1 = Result2 = 0 and Control = 0 the next cycle.
  - Init at Shift 10 with new operands 3 × 5 → the next full run gives 15.
- Extra/idle Shift: after completion apply 5 more Shift pulses → results unchanged. Init and Shift in the same cycle → Init wins, iter = 0.
